// File: rtl/pmp_pkg.sv
// Shared types and defaults for the absolute-phase pipeline scheduler.
package pmp_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DIM_W      = 12;

    typedef logic signed [DEF_DATA_WIDTH-1:0] phase_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/pmp_sync_fifo.sv
// First-word-fall-through synchronous FIFO with full/empty flags.
module pmp_sync_fifo #(
    parameter int DW    = 17,
    parameter int DEPTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          do_wr, do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    // Extra pointer MSB tells a full ring from an empty one.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer advance on accepted writes and reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage array; contents need no reset since empty gates the read side.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/abs_phase_sched.sv
// Frame scheduler for the heterodyne absolute-phase pipeline: joins three
// phase streams, issues only against guaranteed output-FIFO space, and
// replays pipeline results as a backpressured stream with tlast/tuser.
module abs_phase_sched
    import pmp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PIPE_LAT   = 15,
    parameter int FIFO_DEPTH = 32,
    parameter int DIM_W      = DEF_DIM_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [DIM_W-1:0]        width_i,
    input  logic [DIM_W-1:0]        height_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    input  logic [2:0]              s_tvalid_i,
    output logic [2:0]              s_tready_o,
    input  logic [3*DATA_WIDTH-1:0] s_tdata_i,
    output logic                    pipe_vld_o,
    output logic [DATA_WIDTH-1:0]   pipe_phase1_o,
    output logic [DATA_WIDTH-1:0]   pipe_phase2_o,
    output logic [DATA_WIDTH-1:0]   pipe_phase3_o,
    output logic                    pipe_tlast_o,
    input  logic                    pipe_vld_i,
    input  logic [DATA_WIDTH-1:0]   pipe_phase_i,
    input  logic                    pipe_tlast_i,
    output logic                    m_tvalid_o,
    input  logic                    m_tready_i,
    output logic [DATA_WIDTH-1:0]   m_tdata_o,
    output logic                    m_tlast_o,
    output logic                    m_tuser_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = 2 * DIM_W;

    if (FIFO_DEPTH < PIPE_LAT + 2) begin : g_depth_chk
        $error("FIFO_DEPTH must cover PIPE_LAT+2 in-flight results");
    end

    sched_state_t     state_q, state_d;
    logic [DIM_W-1:0] w_q, h_q, col_q, row_q, ocol_q;
    logic [TW-1:0]    total_q, out_cnt_q;
    logic [CW-1:0]    credit_q;
    logic             sof_q, err_q;
    logic             start_ok, issue, col_end, last_issue, pop;
    logic             res_err;
    logic             fifo_full, fifo_empty;
    logic [DATA_WIDTH:0] fifo_rd;

    assign start_ok   = (state_q == IDLE) && start_i && (width_i != '0) && (height_i != '0);
    // All three streams hand over together, and only with room guaranteed downstream.
    assign issue      = (state_q == RUN) && (&s_tvalid_i) && (credit_q != '0);
    assign s_tready_o = {3{issue}};
    assign col_end    = (col_q == w_q - DIM_W'(1));
    assign last_issue = issue && col_end && (row_q == h_q - DIM_W'(1));
    assign pop        = m_tvalid_o && m_tready_i;

    // A result is an error if it overflows, arrives with no frame, or its tlast is misplaced.
    assign res_err = pipe_vld_i && (fifo_full || (state_q == IDLE) ||
                     (pipe_tlast_i != (ocol_q == w_q - DIM_W'(1))));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and status decode.
    always_comb begin
        state_d = state_q;
        done_o  = 1'b0;
        busy_o  = 1'b0;
        unique case (state_q)
            IDLE:  if (start_ok) state_d = RUN;
            RUN: begin
                busy_o = 1'b1;
                if (last_issue) state_d = DRAIN;
            end
            DRAIN: begin
                busy_o = 1'b1;
                if (out_cnt_q == total_q) state_d = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame dimensions, position counters and start-of-frame flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_q       <= '0;
            h_q       <= '0;
            total_q   <= '0;
            col_q     <= '0;
            row_q     <= '0;
            ocol_q    <= '0;
            out_cnt_q <= '0;
            sof_q     <= 1'b0;
        end else if (start_ok) begin
            w_q       <= width_i;
            h_q       <= height_i;
            total_q   <= TW'(width_i) * TW'(height_i);
            col_q     <= '0;
            row_q     <= '0;
            ocol_q    <= '0;
            out_cnt_q <= '0;
            sof_q     <= 1'b1;
        end else begin
            if (issue) begin
                col_q <= col_end ? '0 : col_q + DIM_W'(1);
                if (col_end) row_q <= row_q + DIM_W'(1);
            end
            if (pipe_vld_i && state_q != IDLE)
                ocol_q <= (ocol_q == w_q - DIM_W'(1)) ? '0 : ocol_q + DIM_W'(1);
            if (pop) begin
                out_cnt_q <= out_cnt_q + TW'(1);
                sof_q     <= 1'b0;
            end
        end
    end

    // Output-space credits: one per FIFO slot not yet promised to an issued pixel.
    always_ff @(posedge clk) begin
        if (!rst_n)
            credit_q <= CW'(FIFO_DEPTH);
        else if (issue && !pop)
            credit_q <= credit_q - CW'(1);
        else if (pop && !issue && credit_q != CW'(FIFO_DEPTH))
            credit_q <= credit_q + CW'(1);
    end

    // Sticky error; an accepted start begins a clean frame.
    always_ff @(posedge clk) begin
        if (!rst_n)        err_q <= 1'b0;
        else if (start_ok) err_q <= 1'b0;
        else if (res_err)  err_q <= 1'b1;
    end
    assign err_o = err_q;

    // Registered issue port into the pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_vld_o    <= 1'b0;
            pipe_tlast_o  <= 1'b0;
            pipe_phase1_o <= '0;
            pipe_phase2_o <= '0;
            pipe_phase3_o <= '0;
        end else begin
            pipe_vld_o   <= issue;
            pipe_tlast_o <= issue && col_end;
            if (issue) begin
                pipe_phase1_o <= s_tdata_i[DATA_WIDTH-1:0];
                pipe_phase2_o <= s_tdata_i[2*DATA_WIDTH-1:DATA_WIDTH];
                pipe_phase3_o <= s_tdata_i[3*DATA_WIDTH-1:2*DATA_WIDTH];
            end
        end
    end

    pmp_sync_fifo #(
        .DW    (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (pipe_vld_i),
        .wr_data ({pipe_tlast_i, pipe_phase_i}),
        .rd_en   (m_tready_i),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_tvalid_o = !fifo_empty;
    assign m_tdata_o  = fifo_rd[DATA_WIDTH-1:0];
    assign m_tlast_o  = m_tvalid_o && fifo_rd[DATA_WIDTH];
    assign m_tuser_o  = m_tvalid_o && sof_q;

endmodule

// File: tb/tb_abs_phase_sched.sv
// Bench for abs_phase_sched: fixed-latency pipeline stand-in, randomized
// stream traffic, and a pixel-index scoreboard of the expected output frame.
module tb_abs_phase_sched;

    localparam int DW    = 16;
    localparam int LAT   = 15;
    localparam int DEPTH = 32;
    localparam int DIMW  = 12;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start_i;
    logic [DIMW-1:0] width_i, height_i;
    logic            busy_o, done_o, err_o;
    logic [2:0]      s_tvalid_i, s_tready_o;
    logic [3*DW-1:0] s_tdata_i;
    logic            pipe_vld_o, pipe_tlast_o;
    logic [DW-1:0]   pipe_phase1_o, pipe_phase2_o, pipe_phase3_o;
    logic            pipe_vld_i, pipe_tlast_i;
    logic [DW-1:0]   pipe_phase_i;
    logic            m_tvalid_o, m_tready_i, m_tlast_o, m_tuser_o;
    logic [DW-1:0]   m_tdata_o;

    always #5 clk = ~clk;

    abs_phase_sched #(.DATA_WIDTH(DW), .PIPE_LAT(LAT), .FIFO_DEPTH(DEPTH), .DIM_W(DIMW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .width_i(width_i), .height_i(height_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o), .s_tdata_i(s_tdata_i),
        .pipe_vld_o(pipe_vld_o), .pipe_phase1_o(pipe_phase1_o), .pipe_phase2_o(pipe_phase2_o),
        .pipe_phase3_o(pipe_phase3_o), .pipe_tlast_o(pipe_tlast_o),
        .pipe_vld_i(pipe_vld_i), .pipe_phase_i(pipe_phase_i), .pipe_tlast_i(pipe_tlast_i),
        .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i), .m_tdata_o(m_tdata_o),
        .m_tlast_o(m_tlast_o), .m_tuser_o(m_tuser_o)
    );

    // Stand-in for the absolute-phase math: any fixed function of the three phases.
    function automatic logic [DW-1:0] pfn(input logic [DW-1:0] a, b, c);
        return a + b - c;
    endfunction

    // Fixed-latency pipeline model sharing rst_n; optionally drops one tlast.
    logic [LAT-1:0] pv, pl;
    logic [DW-1:0]  pd [LAT];
    bit             drop_req = 0;
    bit             dropped;
    always @(posedge clk) begin
        if (!rst_n) begin
            pv <= '0;
            pl <= '0;
            dropped <= 1'b0;
        end else begin
            pv <= {pv[LAT-2:0], pipe_vld_o};
            pl <= {pl[LAT-2:0], pipe_tlast_o && !(drop_req && !dropped)};
            if (drop_req && pipe_vld_o && pipe_tlast_o) dropped <= 1'b1;
            pd[0] <= pfn(pipe_phase1_o, pipe_phase2_o, pipe_phase3_o);
            for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
        end
    end
    assign pipe_vld_i   = pv[LAT-1];
    assign pipe_tlast_i = pl[LAT-1];
    assign pipe_phase_i = pd[LAT-1];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected samples are derived from the pixel index within the frame.
    typedef struct { logic [DW-1:0] p1, p2, p3; bit last; } smp_t;
    typedef struct { logic [DW-1:0] d; bit last, user; } out_t;
    smp_t in_q[$];
    out_t out_q[$];

    int cyc = 0, tot_iss = 0, tot_pop = 0, done_cnt = 0;
    int hs[3] = '{0, 0, 0};
    int first_iss_cyc = 0, last_iss_cyc = 0, last_pop_cyc = 0, done_gap = 0;
    int cur_w = 1, b_iss = 0, b_pop = 0;
    int b_hs[3] = '{0, 0, 0};
    bit chk_tlast = 1;

    // Monitor on the falling edge: everything seen here is what the next rising edge commits.
    always @(negedge clk) begin
        smp_t s;
        out_t o;
        int   idx;
        cyc++;
        if (!rst_n) begin
            in_q.delete();
            out_q.delete();
        end else begin
            if (pipe_vld_o) begin
                if (in_q.size() == 0) chk("pipe_unexpected", 32'd1, 32'd0);
                else begin
                    s = in_q.pop_front();
                    chk("pipe_p1", 32'(pipe_phase1_o), 32'(s.p1));
                    chk("pipe_p2", 32'(pipe_phase2_o), 32'(s.p2));
                    chk("pipe_p3", 32'(pipe_phase3_o), 32'(s.p3));
                    chk("pipe_tlast", 32'(pipe_tlast_o), 32'(s.last));
                end
            end
            if (s_tready_o != 3'b000)
                chk("join_all", 32'({s_tready_o, s_tvalid_i}), 32'h3f);
            for (int i = 0; i < 3; i++) if (s_tvalid_i[i] && s_tready_o[i]) hs[i]++;
            if (&(s_tvalid_i & s_tready_o)) begin
                idx = tot_iss - b_iss;
                s.p1 = s_tdata_i[DW-1:0];
                s.p2 = s_tdata_i[2*DW-1:DW];
                s.p3 = s_tdata_i[3*DW-1:2*DW];
                s.last = ((idx % cur_w) == cur_w - 1);
                in_q.push_back(s);
                o.d = pfn(s.p1, s.p2, s.p3);
                o.last = s.last;
                o.user = (idx == 0);
                out_q.push_back(o);
                if (idx == 0) first_iss_cyc = cyc;
                last_iss_cyc = cyc;
                tot_iss++;
            end
            if (m_tvalid_o && m_tready_i) begin
                if (out_q.size() == 0) chk("out_unexpected", 32'd1, 32'd0);
                else begin
                    o = out_q.pop_front();
                    chk("out_data", 32'(m_tdata_o), 32'(o.d));
                    chk("out_tuser", 32'(m_tuser_o), 32'(o.user));
                    if (chk_tlast) chk("out_tlast", 32'(m_tlast_o), 32'(o.last));
                end
                tot_pop++;
                last_pop_cyc = cyc;
            end
            if (done_o) begin
                done_cnt++;
                done_gap = cyc - last_pop_cyc;
            end
        end
    end

    int vmode = 0, rmode = 0;
    bit tog = 0;

    task automatic step();
        @(posedge clk);
        #1;
        s_tdata_i = {16'($urandom), 16'($urandom), 16'($urandom)};
        case (vmode)
            0: s_tvalid_i = 3'b111;
            1: begin s_tvalid_i = {1'b1, tog, 1'b1}; tog = ~tog; end
            2: s_tvalid_i = 3'($urandom);
            default: s_tvalid_i = 3'b000;
        endcase
        case (rmode)
            0: m_tready_i = 1'b1;
            1: m_tready_i = 1'b0;
            default: m_tready_i = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic start_frame(input int w, input int h, input bit acc);
        if (acc) begin
            cur_w = w;
            b_iss = tot_iss;
            b_pop = tot_pop;
            for (int i = 0; i < 3; i++) b_hs[i] = hs[i];
        end
        start_i  = 1'b1;
        width_i  = DIMW'(w);
        height_i = DIMW'(h);
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_done_pulse"}, 32'(done_o), 32'd0);
        chk({tag, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int w, h;
        rst_n = 1'b0; start_i = 1'b0; width_i = '0; height_i = '0;
        s_tvalid_i = '0; s_tdata_i = '0; m_tready_i = 1'b0;
        vmode = 3; rmode = 1;
        repeat (3) step();
        chk("rst_ctrl", 32'({busy_o, done_o, err_o, s_tready_o, pipe_vld_o, pipe_tlast_o, m_tvalid_o}), 32'd0);
        chk("rst_data", 32'({pipe_phase1_o, pipe_phase2_o}), 32'd0);
        rst_n = 1'b1;
        step();

        // Full-rate 4x2 frame.
        vmode = 0; rmode = 0;
        start_frame(4, 2, 1);
        wait_done("t1", 200);
        chk("t1_issues", 32'(tot_iss - b_iss), 32'd8);
        chk("t1_pops", 32'(tot_pop - b_pop), 32'd8);
        chk("t1_b2b", 32'(last_iss_cyc - first_iss_cyc + 1), 32'd8);
        chk("t1_done_gap", 32'(done_gap), 32'd2);
        chk("t1_err", 32'(err_o), 32'd0);

        // Stalled output: exactly FIFO_DEPTH issues, then the rest after release.
        start_frame(64, 1, 1);
        rmode = 1;
        repeat (80) step();
        chk("t2_credit_issues", 32'(tot_iss - b_iss), 32'(DEPTH));
        chk("t2_stalled_rdy", 32'(s_tready_o), 32'd0);
        chk("t2_busy", 32'(busy_o), 32'd1);
        rmode = 0;
        wait_done("t2", 400);
        chk("t2_issues", 32'(tot_iss - b_iss), 32'd64);
        chk("t2_pops", 32'(tot_pop - b_pop), 32'd64);
        chk("t2_err", 32'(err_o), 32'd0);

        // Phase2 valid toggling, random output backpressure.
        vmode = 1; rmode = 2;
        start_frame(5, 3, 1);
        wait_done("t3", 1000);
        for (int i = 0; i < 3; i++) chk("t3_hs", 32'(hs[i] - b_hs[i]), 32'd15);
        chk("t3_pops", 32'(tot_pop - b_pop), 32'd15);

        // Random frames with random valid/ready.
        vmode = 2;
        for (int k = 0; k < 4; k++) begin
            w = $urandom_range(1, 6);
            h = $urandom_range(1, 4);
            start_frame(w, h, 1);
            wait_done("trand", 2000);
            chk("trand_pops", 32'(tot_pop - b_pop), 32'(w * h));
            chk("trand_err", 32'(err_o), 32'd0);
        end

        // Zero-dimension start ignored; start during RUN ignored.
        vmode = 0; rmode = 0;
        start_frame(0, 3, 0);
        repeat (3) step();
        chk("t4_zero_busy", 32'(busy_o), 32'd0);
        start_frame(3, 2, 1);
        step();
        start_frame(7, 7, 0);
        wait_done("t4", 300);
        chk("t4_pops", 32'(tot_pop - b_pop), 32'd6);

        // Reset in the middle of a frame.
        start_frame(8, 4, 1);
        for (int n = 0; n < 50 && (tot_iss - b_iss) < 5; n++) step();
        rst_n = 1'b0;
        step();
        chk("t5_rst_ctrl", 32'({busy_o, done_o, err_o, s_tready_o, pipe_vld_o, pipe_tlast_o, m_tvalid_o}), 32'd0);
        rst_n = 1'b1;
        step();
        start_frame(2, 2, 1);
        wait_done("t5", 300);
        chk("t5_pops", 32'(tot_pop - b_pop), 32'd4);
        // Full credit after reset: a stalled frame takes exactly FIFO_DEPTH issues.
        start_frame(40, 1, 1);
        rmode = 1;
        repeat (60) step();
        chk("t5_credit", 32'(tot_iss - b_iss), 32'(DEPTH));
        rmode = 0;
        wait_done("t5b", 300);

        // Dropped tlast from the pipeline sets a sticky error.
        drop_req = 1; chk_tlast = 0;
        start_frame(4, 3, 1);
        wait_done("t6", 300);
        chk("t6_err_set", 32'(err_o), 32'd1);
        repeat (5) step();
        chk("t6_err_hold", 32'(err_o), 32'd1);
        drop_req = 0; chk_tlast = 1;
        start_frame(2, 1, 1);
        chk("t6_err_clr", 32'(err_o), 32'd0);
        wait_done("t6b", 300);
        chk("t6_err_after", 32'(err_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
